fifo2stream: RTL and testbench
==============================

FIFO2STREAM -- requirements
Module: fifo2stream

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the data word width in bits.
REQ-002 SHALL have parameter LATENCY, default 2, meaning the FIFO read latency in cycles (1 for unregistered RAM output, 2 for registered); legal values are 1 and 2 only, and any other value SHALL produce an elaboration $error.
REQ-003 SHALL derive localparam BUFDEPTH = LATENCY+1, meaning the number of output buffer entries.
REQ-004 clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 fifo_empty  input  1  empty flag of the upstream FIFO read side.
REQ-007 fifo_read  output  1  read strobe to the upstream FIFO.
REQ-008 fifo_q  input  WIDTH  FIFO read data, valid LATENCY cycles after fifo_read.
REQ-009 m_valid  output  1  output stream word valid.
REQ-010 m_ready  input  1  downstream accepts the word.
REQ-011 m_data  output  WIDTH  output stream data.
REQ-012 busy  output  1  high when any word is in flight or buffered.
REQ-013 words  output  32  count of completed output transfers.

Function
REQ-014 SHALL define the following terms: pop = m_valid && m_ready; inflight = number of issued reads whose data has not yet been captured (0..LATENCY); bufcnt = output buffer occupancy (0..BUFDEPTH).
REQ-015 SHALL drive fifo_read combinationally as !fifo_empty && (inflight + bufcnt - pop) < BUFDEPTH.
REQ-016 SHALL never assert fifo_read while fifo_empty = 1.
REQ-017 SHALL track reads with a LATENCY-deep valid shift register: the bit entering is fifo_read, and the bit exiting marks the cycle in which fifo_q holds the corresponding word.
REQ-018 SHALL, when the exiting valid bit is 1, write fifo_q into the buffer at the write pointer on that rising edge.
REQ-019 SHALL implement the buffer as a circular BUFDEPTH-entry array with read and write pointers that wrap from BUFDEPTH-1 to 0, plus an occupancy counter.
REQ-020 SHALL on simultaneous push and pop advance both pointers and leave bufcnt unchanged; push-only SHALL increment bufcnt, and pop-only SHALL decrement it.
REQ-021 SHALL, through the credit rule (REQ-015), prevent buffer overflow; a push when bufcnt = BUFDEPTH without a pop is a design error, flagged by a simulation assertion.
REQ-022 SHALL assert m_valid = (bufcnt != 0) and drive m_data from the entry at the read pointer.
REQ-023 SHALL keep m_data stable, and keep m_valid high, while m_valid && !m_ready.
REQ-024 SHALL have a latency from fifo_read high in cycle t to m_valid high in cycle t+LATENCY+1, with no bypass path.
REQ-025 SHALL, with m_ready held at 1 and FIFO non-empty, sustain one transfer per cycle after the initial latency.
REQ-026 SHALL, when m_ready drops, stop fifo_read within the same cycle once the credits are exhausted, and retain every in-flight word with no loss and no duplication.
REQ-027 SHALL increment words by 1 on each pop and wrap from 2^32-1 to 0.
REQ-028 SHALL assert busy = (inflight != 0) || (bufcnt != 0).
REQ-029 SHALL preserve output order identical to FIFO read order.

Reset
REQ-030 SHALL, on rst high, immediately clear the valid shift register, pointers, bufcnt and words, so that m_valid = 0, busy = 0, words = 0 and fifo_read = 0 while rst is high.
REQ-031 SHALL leave the buffer data array unreset; m_data is don't-care while m_valid = 0.
REQ-032 SHALL discard data read from the FIFO before a mid-operation reset; rst SHALL be driven together with the upstream FIFO reset.
REQ-033 SHALL resume normal operation on the first rising edge after rst deasserts.

Verification
REQ-034 Reset: drive rst high mid-stream with bufcnt = 2 -> m_valid = 0, busy = 0, words = 0 in the same cycle; after release, with the FIFO empty -> fifo_read stays 0.
REQ-035 Single word, LATENCY = 2: fifo_empty falls in cycle 0 with m_ready = 1 -> fifo_read = 1 in cycle 0, m_valid = 1 in cycle 3, words = 1 after cycle 3.
REQ-036 Streaming: FIFO holds 100 words 0..99, m_ready = 1, LATENCY = 1 and 2 -> 100 transfers in order within 100+LATENCY+1 cycles, words = 100.
REQ-037 Backpressure: m_ready = 0 for 10 cycles mid-stream -> at most BUFDEPTH reads outstanding, bufcnt peaks at BUFDEPTH, m_data stable, no word lost or duplicated when m_ready returns to 1.
REQ-038 Random: random fifo_empty and random m_ready at 50% for 10k cycles -> scoreboard exact match, with fifo_read never high while fifo_empty = 1.
REQ-039 Wrap: preload words = 0xFFFFFFFE via force, then 3 transfers -> words = 1.

Source files
------------

// File: rtl/fifo2stream.sv
// fifo2stream: turns a fixed-latency FIFO read port into a valid/ready stream.
// Reads are issued against credits so a small circular buffer absorbs every in-flight word.
module fifo2stream #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    output logic             fifo_read,
    input  logic [WIDTH-1:0] fifo_q,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             busy,
    output logic [31:0]      words
);
    localparam int unsigned BUFDEPTH = LATENCY + 1;
    localparam int unsigned PTR_W    = (BUFDEPTH > 2) ? $clog2(BUFDEPTH) : 1;
    localparam int unsigned CNT_W    = $clog2(BUFDEPTH + 1);
    localparam int unsigned SUM_W    = CNT_W + 2;

    if ((LATENCY != 1) && (LATENCY != 2)) begin : g_bad_latency
        $error("fifo2stream: LATENCY must be 1 or 2, got %0d", LATENCY);
    end

    logic [LATENCY-1:0] vsr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   bufcnt;
    logic [31:0]        words_q;
    logic [WIDTH-1:0]   mem [BUFDEPTH];

    logic             pop;
    logic             push;
    logic [SUM_W-1:0] inflight;
    logic [SUM_W-1:0] credit_use;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUFDEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit check: words already owed to the buffer plus this cycle's issue must fit.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + SUM_W'(vsr[i]);
        end
        m_valid    = (bufcnt != '0);
        pop        = m_valid && m_ready;
        push       = vsr[LATENCY-1];
        credit_use = inflight + SUM_W'(bufcnt) - SUM_W'(pop);
        fifo_read  = !rst && !fifo_empty && (credit_use < SUM_W'(BUFDEPTH));
        busy       = (vsr != '0) || (bufcnt != '0);
        m_data     = mem[rd_ptr];
        words      = words_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsr     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            bufcnt  <= '0;
            words_q <= '0;
        end else begin
            vsr[0] <= fifo_read;
            for (int i = 1; i < LATENCY; i++) begin
                vsr[i] <= vsr[i-1];
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr  <= ptr_inc(rd_ptr);
                words_q <= words_q + 32'd1;
            end
            if (push && !pop) begin
                bufcnt <= bufcnt + CNT_W'(1);
            end else if (pop && !push) begin
                bufcnt <= bufcnt - CNT_W'(1);
            end
        end
    end

    // Data array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= fifo_q;
        end
    end

    // The credit rule should make an overflowing push impossible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && (bufcnt == CNT_W'(BUFDEPTH))))
            else $error("fifo2stream: buffer overflow");
        end
    end
endmodule

// File: tb/tb_fifo2stream.sv
// Directed bench for fifo2stream: LATENCY=1 and LATENCY=2 instances side by side,
// each fed by a counting FIFO model and checked against an in-order scoreboard.
module tb_fifo2stream;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                m_ready;
    logic [1:0]          fifo_empty;
    logic [1:0][W-1:0]   fifo_q;
    logic                fr1, fr2, mv1, mv2, bz1, bz2;
    logic [W-1:0]        md1, md2;
    logic [31:0]         wd1, wd2;
    logic [1:0]          fifo_read, m_valid, busy;
    logic [1:0][W-1:0]   m_data;
    logic [1:0][31:0]    words;

    assign fifo_read = {fr2, fr1};
    assign m_valid   = {mv2, mv1};
    assign busy      = {bz2, bz1};
    assign m_data    = {md2, md1};
    assign words     = {wd2, wd1};

    fifo2stream #(.WIDTH(W), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty[0]), .fifo_read(fr1),
        .fifo_q(fifo_q[0]), .m_valid(mv1), .m_ready(m_ready), .m_data(md1),
        .busy(bz1), .words(wd1)
    );

    fifo2stream #(.WIDTH(W), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty[1]), .fifo_read(fr2),
        .fifo_q(fifo_q[1]), .m_valid(mv2), .m_ready(m_ready), .m_data(md2),
        .busy(bz2), .words(wd2)
    );

    int          checks;
    int          failures;
    int unsigned src_next  [2];
    int unsigned src_avail [2];
    int unsigned exp_next  [2];
    int unsigned popped    [2];
    int unsigned done      [2];
    logic [W-1:0] d1   [2];
    logic [W-1:0] q2   [2];
    logic [W-1:0] hold [2];
    bit           block      [2];
    bit           stall_prev [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd_empty();
        for (int k = 0; k < 2; k++) begin
            fifo_empty[k] = (src_avail[k] == 0) || block[k];
        end
    endtask

    // One clock: sample and score at negedge, then advance the FIFO models after posedge.
    task automatic step();
        bit rd [2];
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            rd[k] = fifo_read[k];
            chk("read_while_empty", 32'(fifo_read[k] & fifo_empty[k]), 32'd0);
            if (stall_prev[k]) begin
                chk("hold_valid", 32'(m_valid[k]), 32'd1);
                chk("hold_data", 32'(m_data[k]), 32'(hold[k]));
            end
            if (m_valid[k] && m_ready) begin
                chk("order", 32'(m_data[k]), 32'(W'(exp_next[k])));
                exp_next[k]++;
                popped[k]++;
            end
            stall_prev[k] = m_valid[k] && !m_ready;
            hold[k]       = m_data[k];
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            q2[k] = d1[k];
            if (rd[k]) begin
                d1[k] = W'(src_next[k]);
                src_next[k]++;
                if (src_avail[k] > 0) src_avail[k]--;
            end
        end
        fifo_q[0] = d1[0];
        fifo_q[1] = q2[1];
        upd_empty();
    endtask

    // Reset both DUTs together with the FIFO models; outputs must clear immediately.
    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            src_avail[k]  = 0;
            block[k]      = 1'b0;
            exp_next[k]   = src_next[k];
            popped[k]     = 0;
            stall_prev[k] = 1'b0;
        end
        upd_empty();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_m_valid", 32'(m_valid[k]), 32'd0);
            chk("rst_busy", 32'(busy[k]), 32'd0);
            chk("rst_words", words[k], 32'd0);
            chk("rst_fifo_read", 32'(fifo_read[k]), 32'd0);
        end
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        m_ready  = 1'b0;
        fifo_q   = '0;
        src_next[0] = 32'h2000;
        src_next[1] = 32'h1000;
        for (int k = 0; k < 2; k++) begin
            src_avail[k] = 0;
            d1[k] = '0;
            q2[k] = '0;
            hold[k] = '0;
            block[k] = 1'b0;
            stall_prev[k] = 1'b0;
        end
        upd_empty();
        #2;
        do_reset();
        step();
        step();
        chk("idle_no_read", 32'(fifo_read[1]), 32'd0);
        chk("idle_busy", 32'(busy[1]), 32'd0);

        // Single word through LATENCY=2: read in cycle 0, valid in cycle 3.
        m_ready = 1'b1;
        src_avail[1] = 1;
        upd_empty();
        #1;
        chk("sw_read_c0", 32'(fifo_read[1]), 32'd1);
        step();
        #1;
        chk("sw_valid_c1", 32'(m_valid[1]), 32'd0);
        chk("sw_busy_c1", 32'(busy[1]), 32'd1);
        step();
        #1;
        chk("sw_valid_c2", 32'(m_valid[1]), 32'd0);
        step();
        #1;
        chk("sw_valid_c3", 32'(m_valid[1]), 32'd1);
        chk("sw_data_c3", 32'(m_data[1]), 32'h1000);
        step();
        #1;
        chk("sw_words", words[1], 32'd1);
        chk("sw_done_valid", 32'(m_valid[1]), 32'd0);
        chk("sw_done_busy", 32'(busy[1]), 32'd0);

        // Mid-stream reset with two words buffered.
        m_ready = 1'b0;
        src_avail[1] = 2;
        upd_empty();
        repeat (6) step();
        chk("pre_rst_bufcnt", 32'(u_l2.bufcnt), 32'd2);
        chk("pre_rst_valid", 32'(m_valid[1]), 32'd1);
        do_reset();
        for (int n = 0; n < 3; n++) begin
            step();
            chk("post_rst_no_read", 32'(fifo_read[1]), 32'd0);
            chk("post_rst_valid", 32'(m_valid[1]), 32'd0);
        end

        // Streaming 100 words through both latencies.
        m_ready = 1'b1;
        src_avail[0] = 100;
        src_avail[1] = 100;
        popped[0] = 0;
        popped[1] = 0;
        done[0] = 0;
        done[1] = 0;
        upd_empty();
        for (int n = 1; n <= 300; n++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                if (done[k] == 0 && popped[k] == 100) done[k] = n;
            end
            if (done[0] != 0 && done[1] != 0) break;
        end
        chk("stream_cycles_l1", done[0], 32'd102);
        chk("stream_cycles_l2", done[1], 32'd103);
        step();
        chk("stream_words_l1", words[0], 32'd100);
        chk("stream_words_l2", words[1], 32'd100);

        // Backpressure: 10 stalled cycles mid-stream.
        popped[0] = 0;
        popped[1] = 0;
        src_avail[0] = 40;
        src_avail[1] = 40;
        upd_empty();
        repeat (10) step();
        m_ready = 1'b0;
        repeat (10) step();
        #1;
        chk("bp_bufcnt_l1", 32'(u_l1.bufcnt), 32'd2);
        chk("bp_bufcnt_l2", 32'(u_l2.bufcnt), 32'd3);
        for (int k = 0; k < 2; k++) begin
            chk("bp_no_read", 32'(fifo_read[k]), 32'd0);
            chk("bp_valid", 32'(m_valid[k]), 32'd1);
            chk("bp_words", words[k], 32'(100 + popped[k]));
        end
        m_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            step();
            if (popped[0] == 40 && popped[1] == 40) break;
        end
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            chk("bp_popped", popped[k], 32'd40);
            chk("bp_no_loss", exp_next[k], src_next[k]);
            chk("bp_words_end", words[k], 32'd140);
            chk("bp_idle", 32'(busy[k]), 32'd0);
        end

        // Random empty and ready, then drain.
        popped[0] = 0;
        popped[1] = 0;
        src_avail[0] = 1000000;
        src_avail[1] = 1000000;
        for (int n = 0; n < 10000; n++) begin
            m_ready  = 1'($urandom_range(0, 1));
            block[0] = 1'($urandom_range(0, 1));
            block[1] = 1'($urandom_range(0, 1));
            upd_empty();
            step();
        end
        m_ready  = 1'b1;
        block[0] = 1'b1;
        block[1] = 1'b1;
        upd_empty();
        repeat (10) step();
        for (int k = 0; k < 2; k++) begin
            chk("rnd_all_delivered", exp_next[k], src_next[k]);
            chk("rnd_words", words[k], 32'(140 + popped[k]));
            chk("rnd_idle", 32'(busy[k]), 32'd0);
        end

        // Transfer counter wrap.
        src_avail[0] = 0;
        src_avail[1] = 0;
        block[0] = 1'b0;
        block[1] = 1'b0;
        upd_empty();
        force u_l2.words_q = 32'hFFFF_FFFE;
        #1;
        release u_l2.words_q;
        #1;
        chk("wrap_preload", words[1], 32'hFFFF_FFFE);
        src_avail[1] = 3;
        upd_empty();
        repeat (10) step();
        chk("wrap_words", words[1], 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
